// File: rtl/sargantana_itag_ctrl.sv
// Icache tag-array controller: fetch lookups, refill tag writes with
// victim selection, and whole-cache flush forwarding to the tag SRAM.
module sargantana_itag_ctrl #(
    parameter int N_WAY = 4,
    parameter int TAG_W = 20,
    parameter int IDX_W = 6
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_i,
    input  logic                   lkp_valid_i,
    output logic                   lkp_ready_o,
    input  logic [IDX_W-1:0]       lkp_idx_i,
    input  logic [TAG_W-1:0]       lkp_tag_i,
    output logic                   resp_valid_o,
    output logic                   resp_hit_o,
    output logic [N_WAY-1:0]       resp_way_o,
    output logic                   resp_multi_o,
    input  logic                   rfl_valid_i,
    output logic                   rfl_ready_o,
    input  logic [IDX_W-1:0]       rfl_idx_i,
    input  logic [TAG_W-1:0]       rfl_tag_i,
    output logic [N_WAY-1:0]       rfl_way_o,
    output logic [N_WAY-1:0]       tmem_req_o,
    output logic                   tmem_we_o,
    output logic                   tmem_vbit_o,
    output logic                   tmem_flush_o,
    output logic [TAG_W-1:0]       tmem_data_o,
    output logic [IDX_W-1:0]       tmem_addr_o,
    input  logic [N_WAY*TAG_W-1:0] tmem_tag_i,
    input  logic [N_WAY-1:0]       tmem_vbit_i
);

    localparam int PTR_W = (N_WAY > 1) ? $clog2(N_WAY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic               ctx_valid_q, ctx_valid_d;
    logic [IDX_W-1:0]   ctx_idx_q, ctx_idx_d;
    logic [N_WAY-1:0]   ctx_vbit_q, ctx_vbit_d;
    logic [TAG_W-1:0]   lkp_tag_q, lkp_tag_d;
    logic [IDX_W-1:0]   lkp_idx_q, lkp_idx_d;

    logic [N_WAY-1:0]   match;
    logic [N_WAY-1:0]   low_match;
    logic               multi;
    logic [N_WAY-1:0]   free_way;
    logic [N_WAY-1:0]   rr_way;
    logic [PTR_W-1:0]   rr_next;
    logic               use_ctx;
    logic               found_m;
    logic               found_f;

    always_comb begin
        match     = '0;
        low_match = '0;
        free_way  = '0;
        found_m   = 1'b0;
        found_f   = 1'b0;
        for (int w = 0; w < N_WAY; w++) begin
            match[w] = tmem_vbit_i[w] &
                       (tmem_tag_i[w*TAG_W +: TAG_W] == lkp_tag_q);
        end
        for (int w = 0; w < N_WAY; w++) begin
            if (match[w] && !found_m) begin
                low_match[w] = 1'b1;
                found_m      = 1'b1;
            end
            if (!ctx_vbit_q[w] && !found_f) begin
                free_way[w] = 1'b1;
                found_f     = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign multi = |(match & (match - N_WAY'(1)));

    always_comb begin
        rr_way       = '0;
        rr_way[rr_q] = 1'b1;
    end

    assign rr_next = (rr_q == PTR_W'(N_WAY - 1)) ? '0 : rr_q + PTR_W'(1);

    assign use_ctx = ctx_valid_q && (ctx_idx_q == rfl_idx_i) && !(&ctx_vbit_q);

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        ctx_valid_d  = ctx_valid_q;
        ctx_idx_d    = ctx_idx_q;
        ctx_vbit_d   = ctx_vbit_q;
        lkp_tag_d    = lkp_tag_q;
        lkp_idx_d    = lkp_idx_q;
        lkp_ready_o  = 1'b0;
        rfl_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_hit_o   = 1'b0;
        resp_way_o   = '0;
        resp_multi_o = 1'b0;
        rfl_way_o    = '0;
        tmem_req_o   = '0;
        tmem_we_o    = 1'b0;
        tmem_vbit_o  = 1'b0;
        tmem_flush_o = 1'b0;
        tmem_data_o  = '0;
        tmem_addr_o  = '0;
        if (rstn_i) begin
            unique case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        tmem_flush_o = 1'b1;
                        ctx_valid_d  = 1'b0;
                        state_d      = FLUSH;
                    end else begin
                        rfl_ready_o = 1'b1;
                        lkp_ready_o = !rfl_valid_i;
                        if (rfl_valid_i) begin
                            rfl_way_o   = use_ctx ? free_way : rr_way;
                            tmem_req_o  = rfl_way_o;
                            tmem_we_o   = 1'b1;
                            tmem_vbit_o = 1'b1;
                            tmem_data_o = rfl_tag_i;
                            tmem_addr_o = rfl_idx_i;
                            ctx_valid_d = 1'b0;
                            if (!use_ctx) begin
                                rr_d = rr_next;
                            end
                        end else if (lkp_valid_i) begin
                            tmem_req_o  = '1;
                            tmem_addr_o = lkp_idx_i;
                            lkp_tag_d   = lkp_tag_i;
                            lkp_idx_d   = lkp_idx_i;
                            state_d     = CMP;
                        end
                    end
                end
                CMP: begin
                    resp_valid_o = 1'b1;
                    if (flush_i) begin
                        tmem_flush_o = 1'b1;
                        ctx_valid_d  = 1'b0;
                        state_d      = FLUSH;
                    end else begin
                        resp_hit_o   = |match;
                        resp_way_o   = low_match;
                        resp_multi_o = multi;
                        state_d      = IDLE;
                        if (!(|match)) begin
                            ctx_idx_d   = lkp_idx_q;
                            ctx_vbit_d  = tmem_vbit_i;
                            ctx_valid_d = 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_i) begin
                        tmem_flush_o = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            ctx_valid_q <= 1'b0;
            ctx_idx_q   <= '0;
            ctx_vbit_q  <= '0;
            lkp_tag_q   <= '0;
            lkp_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            ctx_valid_q <= ctx_valid_d;
            ctx_idx_q   <= ctx_idx_d;
            ctx_vbit_q  <= ctx_vbit_d;
            lkp_tag_q   <= lkp_tag_d;
            lkp_idx_q   <= lkp_idx_d;
        end
    end

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Scoreboard bench for sargantana_itag_ctrl against a behavioural
// registered-read tag SRAM.
module tb_sargantana_itag_ctrl;

    localparam int N_WAY = 4;
    localparam int TAG_W = 20;
    localparam int IDX_W = 6;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   flush;
    logic                   lkp_valid;
    logic                   lkp_ready_o;
    logic [IDX_W-1:0]       lkp_idx;
    logic [TAG_W-1:0]       lkp_tag;
    logic                   resp_valid_o;
    logic                   resp_hit_o;
    logic [N_WAY-1:0]       resp_way_o;
    logic                   resp_multi_o;
    logic                   rfl_valid;
    logic                   rfl_ready_o;
    logic [IDX_W-1:0]       rfl_idx;
    logic [TAG_W-1:0]       rfl_tag;
    logic [N_WAY-1:0]       rfl_way_o;
    logic [N_WAY-1:0]       tmem_req_o;
    logic                   tmem_we_o;
    logic                   tmem_vbit_o;
    logic                   tmem_flush_o;
    logic [TAG_W-1:0]       tmem_data_o;
    logic [IDX_W-1:0]       tmem_addr_o;
    logic [N_WAY*TAG_W-1:0] tmem_tag_i;
    logic [N_WAY-1:0]       tmem_vbit_i;

    int vectors = 0;
    int miscompares = 0;

    logic [5:0]  resp_q[$];
    logic [29:0] rfl_q[$];

    always #5 clk = ~clk;

    sargantana_itag_ctrl #(
        .N_WAY(N_WAY),
        .TAG_W(TAG_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .flush_i      (flush),
        .lkp_valid_i  (lkp_valid),
        .lkp_ready_o  (lkp_ready_o),
        .lkp_idx_i    (lkp_idx),
        .lkp_tag_i    (lkp_tag),
        .resp_valid_o (resp_valid_o),
        .resp_hit_o   (resp_hit_o),
        .resp_way_o   (resp_way_o),
        .resp_multi_o (resp_multi_o),
        .rfl_valid_i  (rfl_valid),
        .rfl_ready_o  (rfl_ready_o),
        .rfl_idx_i    (rfl_idx),
        .rfl_tag_i    (rfl_tag),
        .rfl_way_o    (rfl_way_o),
        .tmem_req_o   (tmem_req_o),
        .tmem_we_o    (tmem_we_o),
        .tmem_vbit_o  (tmem_vbit_o),
        .tmem_flush_o (tmem_flush_o),
        .tmem_data_o  (tmem_data_o),
        .tmem_addr_o  (tmem_addr_o),
        .tmem_tag_i   (tmem_tag_i),
        .tmem_vbit_i  (tmem_vbit_i)
    );

    // Tag SRAM model with a backdoor preload port.
    logic [TAG_W-1:0] m_tag [N_WAY][64];
    logic             m_v   [N_WAY][64];
    logic [TAG_W-1:0] rd_tag [N_WAY];
    logic [N_WAY-1:0] rd_v;
    logic             bd_en = 1'b0;
    logic [1:0]       bd_way;
    logic [IDX_W-1:0] bd_idx;
    logic [TAG_W-1:0] bd_tag;
    logic             bd_v;

    always @(posedge clk) begin
        if (!rstn) begin
            rd_v <= '0;
            for (int w = 0; w < N_WAY; w++)
                for (int s = 0; s < 64; s++)
                    m_v[w][s] <= 1'b0;
        end else if (bd_en) begin
            m_tag[bd_way][bd_idx] <= bd_tag;
            m_v[bd_way][bd_idx]   <= bd_v;
        end else if (tmem_flush_o) begin
            for (int w = 0; w < N_WAY; w++)
                for (int s = 0; s < 64; s++)
                    m_v[w][s] <= 1'b0;
        end else begin
            for (int w = 0; w < N_WAY; w++) begin
                if (tmem_req_o[w]) begin
                    if (tmem_we_o) begin
                        m_tag[w][tmem_addr_o] <= tmem_data_o;
                        m_v[w][tmem_addr_o]   <= tmem_vbit_o;
                    end else begin
                        rd_tag[w] <= m_tag[w][tmem_addr_o];
                        rd_v[w]   <= m_v[w][tmem_addr_o];
                    end
                end
            end
        end
    end

    assign tmem_tag_i  = {rd_tag[3], rd_tag[2], rd_tag[1], rd_tag[0]};
    assign tmem_vbit_i = rd_v;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [5:0]  er;
        logic [29:0] ef;
        if (rstn) begin
            if (resp_valid_o) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    er = resp_q.pop_front();
                    check("resp", {26'd0, resp_multi_o, resp_hit_o, resp_way_o},
                          {26'd0, er});
                end
            end
            if (rfl_valid && rfl_ready_o) begin
                if (rfl_q.size() == 0) begin
                    check("rfl_unexpected", 32'd1, 32'd0);
                end else begin
                    ef = rfl_q.pop_front();
                    check("rfl_way", {2'd0, rfl_way_o, tmem_data_o, tmem_addr_o},
                          {2'd0, ef});
                    check("rfl_wr", {26'd0, tmem_we_o, tmem_vbit_o, tmem_req_o},
                          {26'd0, 2'b11, ef[29:26]});
                end
            end
        end
    end

    task automatic wait_lkp_ready();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lkp_ready_o) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("lkp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_lkp(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                          input logic [5:0] exp);
        resp_q.push_back(exp);
        lkp_idx   = idx;
        lkp_tag   = tag;
        lkp_valid = 1'b1;
        wait_lkp_ready();
        @(posedge clk); #1;
        lkp_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_rfl(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                          input logic [N_WAY-1:0] way);
        bit ok = 0;
        rfl_q.push_back({way, tag, idx});
        rfl_idx   = idx;
        rfl_tag   = tag;
        rfl_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rfl_ready_o) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("rfl_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rfl_valid = 1'b0;
    endtask

    task automatic bd(input logic [1:0] way, input logic [IDX_W-1:0] idx,
                      input logic [TAG_W-1:0] tag, input logic v);
        bd_way = way;
        bd_idx = idx;
        bd_tag = tag;
        bd_v   = v;
        bd_en  = 1'b1;
        @(posedge clk); #1;
        bd_en  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        lkp_valid = 1'b0;
        rfl_valid = 1'b0;
        lkp_idx   = '0;
        lkp_tag   = '0;
        rfl_idx   = '0;
        rfl_tag   = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_outs", {24'd0, resp_valid_o, tmem_req_o, tmem_we_o,
              tmem_flush_o, resp_hit_o}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("idle_ready", {30'd0, lkp_ready_o, rfl_ready_o}, 32'd3);
        @(posedge clk); #1;

        // Cold miss then refill into the miss context's first free way.
        do_lkp(6'd5, 20'hABCDE, 6'b00_0000);
        do_rfl(6'd5, 20'hABCDE, 4'b0001);

        // Round-robin victims without a miss context.
        for (int i = 0; i < 5; i++)
            do_rfl(6'd7, 20'h70000 + 20'(i), 4'(1 << (i % 4)));

        // Miss context with vbits 1011 picks way 2; rr pointer untouched.
        bd(2'd0, 6'd3, 20'h11111, 1'b1);
        bd(2'd1, 6'd3, 20'h22222, 1'b1);
        bd(2'd2, 6'd3, 20'h44444, 1'b0);
        bd(2'd3, 6'd3, 20'h33333, 1'b1);
        do_lkp(6'd3, 20'h55555, 6'b00_0000);
        do_rfl(6'd3, 20'h55555, 4'b0100);
        do_rfl(6'd9, 20'h99999, 4'b0010);

        // Multi-way hit resolves to the lowest matching way.
        bd(2'd0, 6'd10, 20'hCAFE0, 1'b1);
        bd(2'd1, 6'd10, 20'hBEEF1, 1'b1);
        bd(2'd2, 6'd10, 20'hBEEF1, 1'b1);
        bd(2'd3, 6'd10, 20'hBEEF1, 1'b0);
        do_lkp(6'd10, 20'hBEEF1, 6'b11_0010);
        do_lkp(6'd5, 20'hABCDE, 6'b01_0001);
        do_lkp(6'd7, 20'h70003, 6'b01_1000);
        do_lkp(6'd7, 20'h70000, 6'b00_0000);

        // Flush during compare suppresses the hit.
        resp_q.push_back(6'b00_0000);
        lkp_idx   = 6'd5;
        lkp_tag   = 20'hABCDE;
        lkp_valid = 1'b1;
        wait_lkp_ready();
        @(posedge clk); #1;
        lkp_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        check("cmp_flush", {29'd0, tmem_flush_o, lkp_ready_o, rfl_ready_o}, 32'd4);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_state", {26'd0, lkp_ready_o, rfl_ready_o, tmem_req_o},
              32'd0);
        check("flush_one_cycle", {31'd0, tmem_flush_o}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("after_flush", {30'd0, lkp_ready_o, rfl_ready_o}, 32'd3);
        @(posedge clk); #1;
        do_lkp(6'd5, 20'hABCDE, 6'b00_0000);

        // Flush in IDLE blocks a pending refill and drops the miss context.
        rfl_valid = 1'b1;
        rfl_idx   = 6'd5;
        rfl_tag   = 20'h0F0F0;
        flush     = 1'b1;
        @(negedge clk);
        check("idle_flush", {26'd0, rfl_ready_o, tmem_flush_o, tmem_req_o},
              32'h10);
        @(posedge clk); #1;
        flush     = 1'b0;
        rfl_valid = 1'b0;
        @(posedge clk); #1;
        do_rfl(6'd5, 20'h0F0F0, 4'b0100);

        // Simultaneous refill and lookup: refill wins, lookup follows.
        rfl_q.push_back({4'b1000, 20'h12345, 6'd20});
        resp_q.push_back(6'b01_1000);
        rfl_idx   = 6'd20;
        rfl_tag   = 20'h12345;
        rfl_valid = 1'b1;
        lkp_idx   = 6'd20;
        lkp_tag   = 20'h12345;
        lkp_valid = 1'b1;
        @(negedge clk);
        check("both_ready", {30'd0, lkp_ready_o, rfl_ready_o}, 32'd1);
        @(posedge clk); #1;
        rfl_valid = 1'b0;
        @(negedge clk);
        check("lkp_next_cycle", {31'd0, lkp_ready_o}, 32'd1);
        @(posedge clk); #1;
        lkp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("resp_q_drained", resp_q.size(), 32'd0);
        check("rfl_q_drained", rfl_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
